// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : Host-to-device PS/2 transmitter. Accepts a command byte, pulls
//             the clock line low to request to send, then shifts start, data
//             (LSB first), odd parity and stop bits out on the falling edges
//             supplied by the device, and checks the device acknowledge.
//  Ports    : clock, reset        - system clock, synchronous active-high reset
//             tx_data/tx_valid    - byte and request, accepted when tx_ready=1
//             tx_ready, busy      - idle indication and its complement
//             tx_done, tx_err     - one-cycle completion / failure pulses
//             ps2_clk_in/data_in  - raw (asynchronous) pin levels
//             ps2_clk_oe/data_oe  - 1 pulls the corresponding line low
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAX_COUNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW        = $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } state_t;

  state_t        state;
  logic [9:0]    shift;     // {stop, parity, data[7:0]}, shifted out LSB first
  logic [3:0]    bit_cnt;   // falling edges seen in SEND
  logic [CW-1:0] cnt;       // inhibit length, then elapsed cycles since START

  logic clk_meta, clk_s, clk_s_d, data_meta, data_s, fall;

  // Synchronisers idle high so a reset never manufactures a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      clk_s_d   <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
      fall      <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_s     <= clk_meta;
      clk_s_d   <= clk_s;
      data_meta <= ps2_data_in;
      data_s    <= data_meta;
      fall      <= clk_s_d & ~clk_s;
    end
  end

  assign busy = ~tx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      shift       <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift       <= {1'b1, ~^tx_data, tx_data};
            bit_cnt     <= '0;
            cnt         <= '0;
            tx_ready    <= 1'b0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            state       <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b1;   // start bit, clock still held low
            state       <= START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        START: begin
          // The START cycle itself is the first elapsed timeout cycle, so the
          // error pulse lands exactly TIMEOUT_CYCLES after START.
          cnt        <= CW'(1);
          ps2_clk_oe <= 1'b0;
          state      <= SEND;
        end

        SEND, ACK, WAIT_IDLE: begin
          // Timeout is evaluated first so it wins over a coincident edge.
          if (cnt == TIMEOUT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            state       <= ERROR;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == SEND) begin
              if (fall) begin
                ps2_data_oe <= ~shift[0];
                shift       <= {1'b0, shift[9:1]};
                bit_cnt     <= bit_cnt + 1'b1;
                if (bit_cnt == 4'd9) begin
                  state <= ACK;
                end
              end
            end else if (state == ACK) begin
              if (fall) begin
                if (data_s) begin
                  tx_err <= 1'b1;
                  state  <= ERROR;
                end else begin
                  state <= WAIT_IDLE;
                end
              end
            end else begin
              if (clk_s && data_s) begin
                tx_done <= 1'b1;
                state   <= DONE;
              end
            end
          end
        end

        DONE: begin
          tx_ready <= 1'b1;
          state    <= IDLE;
        end

        ERROR: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_ready    <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
